// File: rtl/bcd_sevenseg_scanner.sv
// rtl/bcd_sevenseg_scanner.sv - time-multiplexed BCD 7-segment scanner
// Snapshot of packed BCD digits, scanned one per refresh slot with guard and leading-zero blanking.
module bcd_sevenseg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_LEAD  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    scan_tick
);

  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST_P  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_P = PW'(GUARD);
  localparam logic [IW-1:0] LAST_I  = IW'(NUM_DIGITS - 1);
  localparam logic          POL     = (ACTIVE_LOW != 0);

  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [NUM_DIGITS-1:0]   r_dps;
  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_tick;

  logic                    w_wrap;
  logic                    w_frame;
  logic [3:0]              w_digit;
  logic                    w_dpsel;
  logic                    w_blank;
  logic                    w_zero_run;
  logic [6:0]              w_seg_hi;
  logic                    w_dp_hi;
  logic [NUM_DIGITS-1:0]   w_an_hi;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h3F;
      4'd1:    f_decode = 7'h06;
      4'd2:    f_decode = 7'h5B;
      4'd3:    f_decode = 7'h4F;
      4'd4:    f_decode = 7'h66;
      4'd5:    f_decode = 7'h6D;
      4'd6:    f_decode = 7'h7D;
      4'd7:    f_decode = 7'h07;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h6F;
      default: f_decode = 7'h40;
    endcase
  endfunction

  assign w_wrap  = (r_presc == LAST_P);
  assign w_frame = w_wrap && (r_idx == LAST_I);

  // Walk from the most significant digit down so the zero run covers digits i..NUM_DIGITS-1.
  always_comb begin
    w_digit    = 4'd0;
    w_dpsel    = 1'b0;
    w_blank    = 1'b0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_snap[4*i +: 4] == 4'd0);
      if (r_idx == IW'(i)) begin
        w_digit = r_snap[4*i +: 4];
        w_dpsel = r_dps[i];
        w_blank = (BLANK_LEAD != 0) && (i != 0) && w_zero_run;
      end
    end
  end

  assign w_seg_hi = w_blank ? 7'h00 : f_decode(w_digit);
  assign w_dp_hi  = w_dpsel & ~w_blank;
  assign w_an_hi  = (r_presc < GUARD_P) ? '0 : (NUM_DIGITS'(1) << r_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap  <= '0;
      r_dps   <= '0;
      r_presc <= '0;
      r_idx   <= '0;
      r_tick  <= 1'b0;
      r_seg   <= {7{POL}};
      r_dp    <= POL;
      r_an    <= {NUM_DIGITS{POL}};
    end else begin
      if (load) begin
        r_snap <= digits_in;
        r_dps  <= dp_in;
      end
      if (w_wrap) begin
        r_presc <= '0;
        r_idx   <= (r_idx == LAST_I) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_tick <= w_frame;
      r_seg  <= w_seg_hi ^ {7{POL}};
      r_dp   <= w_dp_hi ^ POL;
      r_an   <= w_an_hi ^ {NUM_DIGITS{POL}};
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign an        = r_an;
  assign scan_tick = r_tick;

endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
// tb/tb_bcd_sevenseg_scanner.sv - self-checking bench for bcd_sevenseg_scanner
// Model tracks cycles since reset; slot/digit and display are derived arithmetically.
module tb_bcd_sevenseg_scanner;

  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int GRD = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   digits_in = 16'h0;
  logic [3:0]    dp_in = 4'h0;
  logic          load = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          scan_tick;

  bcd_sevenseg_scanner #(
    .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .GUARD(GRD), .ACTIVE_LOW(1), .BLANK_LEAD(1)
  ) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .seg(seg), .dp(dp), .an(an), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic [3:0] an_seq [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                              4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

  int          m_cnt = 0;
  logic [15:0] m_snap = 16'h0;
  logic [3:0]  m_dps = 4'h0;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_tick;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge: expected outputs come from the model state before the edge.
  task automatic step();
    int pre, slot, idx, d;
    bit blank;
    @(posedge clk);
    if (reset) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_tick = 1'b0;
      m_cnt = 0; m_snap = 16'h0; m_dps = 4'h0;
    end else begin
      pre   = m_cnt;
      slot  = pre % DIV;
      idx   = (pre / DIV) % ND;
      d     = int'((m_snap >> (4 * idx)) & 16'hF);
      blank = (idx != 0) && ((m_snap >> (4 * idx)) == 16'h0);
      e_seg  = ~(blank ? 7'h00 : seg_tab[d]);
      e_dp   = ~(m_dps[idx] && !blank);
      e_an   = (slot < GRD) ? 4'hF : ~(4'(1) << idx);
      e_tick = ((pre % (DIV * ND)) == DIV * ND - 1);
      if (load) begin
        m_snap = digits_in;
        m_dps  = dp_in;
      end
      m_cnt++;
    end
    #1;
    chk("seg", int'(seg), int'(e_seg));
    chk("dp", int'(dp), int'(e_dp));
    chk("an", int'(an), int'(e_an));
    chk("scan_tick", int'(scan_tick), int'(e_tick));
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] p);
    digits_in = v; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int ticks, dplow, idx;

    // Reset asserted mid-slot takes effect without a clock edge.
    reset = 1'b1;
    #2;
    chk("rst_seg", int'(seg), 'h7F);
    chk("rst_dp", int'(dp), 1);
    chk("rst_an", int'(an), 'hF);
    chk("rst_tick", int'(scan_tick), 0);
    step();
    step();
    reset = 1'b0;
    load_val(16'h0000, 4'h0);
    repeat (5) step();
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst_an", int'(an), 'hF);
    chk("midrst_seg", int'(seg), 'h7F);
    step();
    reset = 1'b0;

    // Release, load 1234 on the first edge, then check one full frame of anodes.
    load_val(16'h1234, 4'h0);
    chk("an_first", int'(an), 'hF);
    ticks = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      chk("an_seq", int'(an), int'(an_seq[k]));
      if (an == 4'hE) chk("seg_four", int'(seg), 'h19);
      if (an == 4'h7) chk("seg_one", int'(seg), 'h79);
      if (scan_tick) ticks++;
    end
    for (int k = 0; k < 32; k++) begin
      step();
      if (scan_tick) ticks++;
    end
    chk("tick_count", ticks, 3);

    // Leading-zero blanking.
    load_val(16'h0070, 4'h0);
    for (int k = 0; k < 16; k++) begin
      idx = (m_cnt / DIV) % ND;
      step();
      chk("blank70", int'(seg), (idx >= 2) ? 'h7F : (idx == 1) ? 'h78 : 'h40);
    end
    load_val(16'h0000, 4'h0);
    for (int k = 0; k < 16; k++) begin
      idx = (m_cnt / DIV) % ND;
      step();
      chk("blank00", int'(seg), (idx == 0) ? 'h40 : 'h7F);
    end

    // Invalid code on digit 0 shows a dash.
    load_val(16'h000A, 4'h0);
    for (int k = 0; k < 16; k++) begin
      idx = (m_cnt / DIV) % ND;
      step();
      if (idx == 0) chk("dash", int'(seg), 'h3F);
    end

    // Mid-slot load: display follows one cycle after the load edge.
    load_val(16'h1234, 4'h0);
    for (int k = 0; k < 32 && (m_cnt % 16) != 2; k++) step();
    load_val(16'h1239, 4'h0);
    chk("midload_old", int'(seg), 'h19);
    step();
    chk("midload_new", int'(seg), 'h10);
    chk("midload_an", int'(an), 'hE);

    // Decimal point on digit 1 only.
    load_val(16'h1234, 4'b0010);
    dplow = 0;
    for (int k = 0; k < 16; k++) begin
      idx = (m_cnt / DIV) % ND;
      step();
      if (!dp) begin
        dplow++;
        chk("dp_digit", idx, 1);
      end
    end
    chk("dp_count", dplow, 4);

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int n = 0; n < 4; n++)
          digits_in[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        dp_in = 4'($urandom_range(0, 15));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
